// File: rtl/ov7670_sensor_emulator_if.sv
// Camera-side video bus of the OV7670 emulator: frame sync, line valid and pixel byte.
interface ov7670_sensor_emulator_if;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output vsync, output href, output data);
  modport slave  (input  vsync, input  href, input  data);
endinterface

// File: rtl/ov7670_sensor_emulator.sv
// OV7670 sensor stand-in: produces vsync/href/RGB565 byte timing and deterministic test frames.
//   state  | meaning
//   IDLE   | no frame running, outputs quiet
//   VSYNC  | vsync high for V_SYNC_LINES line periods
//   VBACK  | back porch lines before the first active line
//   ACTIVE | V_ACTIVE lines of pixel bytes with href
//   VFRONT | front porch lines; frame ends on its last cycle
module ov7670_sensor_emulator #(
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int H_BLANK       = 144,
  parameter int V_SYNC_LINES  = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10
) (
  input  logic                               ov7670_pclk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [1:0]                         pattern_sel,
  input  logic [3:0]                         zone,
  input  logic [15:0]                        solid_rgb,
  ov7670_sensor_emulator_if.master           cam,
  output logic                               frame_done,
  output logic [15:0]                        frame_count,
  output logic                               busy
);

  localparam int          LINE        = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] H_LAST      = 16'(LINE - 1);
  localparam logic [15:0] H_ACT_BYTES = 16'(2 * H_ACTIVE);
  localparam logic [15:0] FRONT_LAST  = 16'(V_FRONT_LINES - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t      state, nxt_state;
  logic [15:0] hcnt, nxt_hcnt, lcnt, nxt_lcnt;
  logic [15:0] state_lines;
  logic        line_end, state_end;
  logic [1:0]  sel_q;
  logic [3:0]  zone_q;
  logic [15:0] rgb_q;

  logic [14:0] px;
  logic [15:0] py, bx, by, pix;
  logic        in_box, href_nxt, done_nxt, frame_start;
  logic [7:0]  data_nxt;

  always_comb begin
    state_lines = 16'd1;
    case (state)
      VSYNC:   state_lines = 16'(V_SYNC_LINES);
      VBACK:   state_lines = 16'(V_BACK_LINES);
      ACTIVE:  state_lines = 16'(V_ACTIVE);
      VFRONT:  state_lines = 16'(V_FRONT_LINES);
      default: state_lines = 16'd1;
    endcase
    line_end  = (hcnt == H_LAST);
    state_end = line_end && (lcnt == state_lines - 16'd1);

    nxt_state = state;
    nxt_hcnt  = 16'd0;
    nxt_lcnt  = 16'd0;
    if (state == IDLE) begin
      if (en) nxt_state = VSYNC;
    end else begin
      nxt_hcnt = line_end ? 16'd0 : hcnt + 16'd1;
      nxt_lcnt = line_end ? lcnt + 16'd1 : lcnt;
      if (state_end) begin
        nxt_lcnt = 16'd0;
        case (state)
          VSYNC:   nxt_state = VBACK;
          VBACK:   nxt_state = ACTIVE;
          ACTIVE:  nxt_state = VFRONT;
          VFRONT:  nxt_state = en ? VSYNC : IDLE;
          default: nxt_state = IDLE;
        endcase
      end
    end
  end

  // Pixel for the position being entered, so outputs register in step with the state.
  always_comb begin
    px = nxt_hcnt[15:1];
    py = nxt_lcnt;
    case (zone_q)
      4'd0, 4'd3, 4'd6: bx = 16'd29;
      4'd1, 4'd4, 4'd7: bx = 16'd136;
      default:          bx = 16'd243;
    endcase
    case (zone_q)
      4'd0, 4'd1, 4'd2: by = 16'd16;
      4'd3, 4'd4, 4'd5: by = 16'd96;
      default:          by = 16'd176;
    endcase
    in_box = (zone_q < 4'd9) &&
             ({1'b0, px} >= bx) && ({1'b0, px} <= bx + 16'd47) &&
             (py >= by) && (py <= by + 16'd47);

    pix = 16'h0000;
    case (sel_q)
      2'b00: begin
        case (px / 15'd40)
          15'd0:   pix = 16'hFFFF;
          15'd1:   pix = 16'hFFE0;
          15'd2:   pix = 16'h07FF;
          15'd3:   pix = 16'h07E0;
          15'd4:   pix = 16'hF81F;
          15'd5:   pix = 16'hF800;
          15'd6:   pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'b01:   pix = in_box ? 16'hF800 : 16'h0000;
      2'b10:   pix = {px[8:4], py[7:2], 5'b00000};
      default: pix = rgb_q;
    endcase

    href_nxt    = (nxt_state == ACTIVE) && (nxt_hcnt < H_ACT_BYTES);
    data_nxt    = href_nxt ? (nxt_hcnt[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    done_nxt    = (nxt_state == VFRONT) && (nxt_hcnt == H_LAST) && (nxt_lcnt == FRONT_LAST);
    frame_start = (nxt_state == VSYNC) && (state != VSYNC);
  end

  always_ff @(posedge ov7670_pclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hcnt        <= 16'd0;
      lcnt        <= 16'd0;
      sel_q       <= 2'b00;
      zone_q      <= 4'd0;
      rgb_q       <= 16'h0000;
      cam.vsync   <= 1'b0;
      cam.href    <= 1'b0;
      cam.data    <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
      busy        <= 1'b0;
    end else begin
      state <= nxt_state;
      hcnt  <= nxt_hcnt;
      lcnt  <= nxt_lcnt;
      // Frame configuration is frozen for the whole frame at VSYNC entry.
      if (frame_start) begin
        sel_q  <= pattern_sel;
        zone_q <= zone;
        rgb_q  <= solid_rgb;
      end
      cam.vsync  <= (nxt_state == VSYNC);
      cam.href   <= href_nxt;
      cam.data   <= data_nxt;
      frame_done <= done_nxt;
      if (done_nxt) frame_count <= frame_count + 16'd1;
      busy <= (nxt_state != IDLE);
    end
  end

endmodule

// File: tb/tb_ov7670_sensor_emulator.sv
// Self-checking bench for the OV7670 emulator on a shrunken frame geometry.
module tb_ov7670_sensor_emulator;

  localparam int HA = 80, VA = 64, HB = 16, VS = 2, VBK = 3, VF = 2;
  localparam int L         = 2 * HA + HB;
  localparam int FRAME     = (VS + VBK + VA + VF) * L;
  localparam int VS_HIGH   = VS * L;
  localparam int BACK      = VBK * L;
  localparam int FALL2RISE = (VBK + VA + VF) * L;

  logic        ov7670_pclk;
  logic        reset;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [3:0]  zone;
  logic [15:0] solid_rgb;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;

  ov7670_sensor_emulator_if cam ();

  ov7670_sensor_emulator #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .V_SYNC_LINES(VS), .V_BACK_LINES(VBK), .V_FRONT_LINES(VF)
  ) dut (
    .ov7670_pclk (ov7670_pclk),
    .reset       (reset),
    .en          (en),
    .pattern_sel (pattern_sel),
    .zone        (zone),
    .solid_rgb   (solid_rgb),
    .cam         (cam.master),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .busy        (busy)
  );

  initial ov7670_pclk = 1'b0;
  always #5 ov7670_pclk = ~ov7670_pclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  int box_x [3] = '{29, 136, 243};
  int box_y [3] = '{16, 96, 176};

  function automatic logic [15:0] model_pix(input logic [1:0] sel, input logic [3:0] z,
                                            input logic [15:0] rgb, input int x, input int y);
    logic [8:0] xv;
    logic [7:0] yv;
    int ox, oy;
    xv = 9'(x);
    yv = 8'(y);
    case (sel)
      2'b00: return bar_tab[x / 40];
      2'b01: begin
        if (z >= 4'd9) return 16'h0000;
        ox = box_x[int'(z) % 3];
        oy = box_y[int'(z) / 3];
        return (x >= ox && x < ox + 48 && y >= oy && y < oy + 48) ? 16'hF800 : 16'h0000;
      end
      2'b10: return {xv[8:4], yv[7:2], 5'b00000};
      default: return rgb;
    endcase
  endfunction

  // Scoreboard and timing monitor
  logic [8:0]  sb_q [$];
  logic [15:0] cap [0:VA-1][0:HA-1];
  int mcyc = 0, rise_cyc = 0, fall_cyc = 0, href_rise = 0;
  int lines = 0, bidx = 0, blank_errs = 0;
  logic vs_prev = 0, href_prev = 0, done_prev = 0, in_frame = 0, first_href = 0;
  logic [15:0] fc_model = 0;

  always @(negedge ov7670_pclk) begin
    logic [8:0] exp_b;
    logic [15:0] p;
    mcyc++;
    if (reset) begin
      sb_q.delete();
      vs_prev = 0; href_prev = 0; done_prev = 0; in_frame = 0; first_href = 0;
      lines = 0; bidx = 0; blank_errs = 0; fc_model = 0;
    end else begin
      if (cam.vsync && !vs_prev) begin
        if (done_prev) chk("fall_to_rise", 32'(mcyc - fall_cyc), 32'(FALL2RISE));
        rise_cyc = mcyc; in_frame = 1; first_href = 1; lines = 0; blank_errs = 0;
        sb_q.delete();
        for (int y = 0; y < VA; y++)
          for (int x = 0; x < HA; x++) begin
            p = model_pix(pattern_sel, zone, solid_rgb, x, y);
            sb_q.push_back({1'b0, p[15:8]});
            sb_q.push_back({1'b0, p[7:0]});
          end
      end
      if (!cam.vsync && vs_prev && in_frame) begin
        chk("vsync_high", 32'(mcyc - rise_cyc), 32'(VS_HIGH));
        fall_cyc = mcyc;
      end
      if (cam.href && !href_prev) begin
        if (first_href) chk("back_porch", 32'(mcyc - fall_cyc), 32'(BACK));
        first_href = 0; href_rise = mcyc; bidx = 0;
      end
      if (cam.href) begin
        exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h100;
        chk("pix_byte", {23'd0, 1'b0, cam.data}, {23'd0, exp_b});
        if (lines < VA && bidx / 2 < HA) begin
          if (bidx % 2 == 0) cap[lines][bidx / 2][15:8] = cam.data;
          else               cap[lines][bidx / 2][7:0]  = cam.data;
        end
        bidx++;
      end else if (cam.data != 8'h00) begin
        blank_errs++;
      end
      if (!cam.href && href_prev) begin
        chk("href_len", 32'(mcyc - href_rise), 32'(2 * HA));
        lines++;
      end
      if (frame_done) begin
        fc_model++;
        chk("done_pulse", {31'd0, done_prev}, 32'd0);
        chk("frame_len", 32'(mcyc - rise_cyc), 32'(FRAME - 1));
        chk("href_lines", 32'(lines), 32'(VA));
        chk("blank_data", 32'(blank_errs), 32'd0);
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        chk("fc_inc", {16'd0, frame_count}, {16'd0, fc_model});
        in_frame = 0;
      end
      vs_prev = cam.vsync; href_prev = cam.href; done_prev = frame_done;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge ov7670_pclk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < FRAME + 1000; i++) begin
      @(negedge ov7670_pclk);
      if (frame_done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vsync"}, {31'd0, cam.vsync}, 32'd0);
    chk({tag, "_href"},  {31'd0, cam.href},  32'd0);
    chk({tag, "_data"},  {24'd0, cam.data},  32'd0);
    chk({tag, "_done"},  {31'd0, frame_done}, 32'd0);
    chk({tag, "_fc"},    {16'd0, frame_count}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; pattern_sel = 2'b00; zone = 4'd0; solid_rgb = 16'h0000;
    wait_cycles(3);
    chk_all_zero("rst");
    reset = 1'b0;
    wait_cycles(3);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_vsync", {31'd0, cam.vsync}, 32'd0);

    // Frame 1: colour bars; switch to solid mid-frame
    en = 1'b1;
    @(posedge ov7670_pclk); #1;
    chk("start_vsync", {31'd0, cam.vsync}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    wait_cycles(35 * L);
    pattern_sel = 2'b11; solid_rgb = 16'h1234;
    wait_done();
    chk("bar_p0", {16'd0, cap[0][0]}, 32'hFFFF);
    chk("bar_p39", {16'd0, cap[0][39]}, 32'hFFFF);
    chk("bar_p40", {16'd0, cap[0][40]}, 32'hFFE0);
    chk("bar_last", {16'd0, cap[63][79]}, 32'hFFE0);

    // Frame 2: solid
    wait_cycles(35 * L);
    pattern_sel = 2'b01; zone = 4'd0;
    wait_done();
    chk("solid_px", {16'd0, cap[10][10]}, 32'h1234);
    chk("solid_px2", {16'd0, cap[63][79]}, 32'h1234);

    // Frame 3: red box in zone 0
    wait_cycles(35 * L);
    pattern_sel = 2'b10;
    wait_done();
    chk("box_tl", {16'd0, cap[16][29]}, 32'hF800);
    chk("box_br", {16'd0, cap[63][76]}, 32'hF800);
    chk("box_left", {16'd0, cap[16][28]}, 32'h0000);
    chk("box_right", {16'd0, cap[63][77]}, 32'h0000);
    chk("box_above", {16'd0, cap[15][29]}, 32'h0000);

    // Frame 4: gradient
    wait_cycles(35 * L);
    pattern_sel = 2'b01; zone = 4'd12;
    wait_done();
    chk("grad_a", {16'd0, cap[5][40]}, 32'h1020);
    chk("grad_b", {16'd0, cap[63][79]}, 32'h21E0);

    // Frame 5: no-box zone, en dropped during active line 30
    wait_cycles(35 * L);
    en = 1'b0;
    wait_done();
    chk("nobox_px", {16'd0, cap[20][40]}, 32'h0000);
    chk("drop_fc", {16'd0, frame_count}, 32'd5);
    @(posedge ov7670_pclk); #1;
    chk("drop_busy", {31'd0, busy}, 32'd0);
    chk("drop_vsync", {31'd0, cam.vsync}, 32'd0);
    wait_cycles(2 * L);
    chk("drop_stay_fc", {16'd0, frame_count}, 32'd5);
    chk("drop_stay_busy", {31'd0, busy}, 32'd0);

    // Reset mid-line during ACTIVE, then a full frame
    pattern_sel = 2'b00; en = 1'b1;
    wait_cycles(15 * L + 50);
    chk("pre_rst_href", {31'd0, cam.href}, 32'd1);
    @(posedge ov7670_pclk); #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    wait_cycles(3);
    reset = 1'b0;
    @(posedge ov7670_pclk); #1;
    chk("rst_vsync", {31'd0, cam.vsync}, 32'd1);
    wait_done();
    chk("rst_fc", {16'd0, frame_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_sensor_emulator.md
# ov7670_sensor_emulator

Synthesizable OV7670 sensor model that drives the camera side of the capture path: `vsync`, `href` and an 8-bit RGB565 byte stream, with the same timing the capture logic and frame buffer expect from the real sensor. It sits in place of the physical camera for bench and board bring-up, clocked by `ov7670_pclk`. It produces deterministic test frames, including a red box placed in one of the 9 detection zones, so that `led`/UART zone results can be checked end-to-end.

## Interface
Parameters:
- `H_ACTIVE`, 320: active pixels per line. Each pixel is 2 bytes.
- `V_ACTIVE`, 240: active lines per frame.
- `H_BLANK`, 144: pclk cycles with `href` low after each line's active bytes.
- `V_SYNC_LINES`, 3: line periods with `vsync` high.
- `V_BACK_LINES`, 17: line periods between `vsync` fall and the first active line.
- `V_FRONT_LINES`, 10: line periods after the last active line.

Ports:
- `ov7670_pclk`, in, 1: pixel-byte clock.
- `reset`, in, 1: reset; asynchronous, active-high; clock `ov7670_pclk`.
- `en`, in, 1: run frames continuously while high.
- `pattern_sel`, in, 2: 00 colour bars, 01 red box, 10 gradient, 11 solid.
- `zone`, in, 4: red-box zone 0..8, row-major; 9..15 means no box.
- `solid_rgb`, in, 16: RGB565 value for the solid pattern.
- `vsync`, out, 1: frame sync, active high.
- `href`, out, 1: line valid.
- `data`, out, 8: pixel byte.
- `frame_done`, out, 1: one-cycle pulse on the last cycle of each frame.
- `frame_count`, out, 16: number of completed frames; wraps.
- `busy`, out, 1: high while not in IDLE.

## Operation
- Line period L = 2·H_ACTIVE + H_BLANK. With defaults, L = 784 cycles.
- FSM states and transitions:
  - IDLE → VSYNC when `en` = 1.
  - VSYNC lasts V_SYNC_LINES·L cycles, then → VBACK.
  - VBACK lasts V_BACK_LINES·L cycles, then → ACTIVE.
  - ACTIVE runs V_ACTIVE lines, then → VFRONT.
  - VFRONT lasts V_FRONT_LINES·L cycles. At its end, go → VSYNC if `en` = 1, else → IDLE.
- Counters:
  - Horizontal cycle counter, 0..L-1.
  - Line counter, counting within the current state.
  - Pixel x = hcnt >> 1; byte phase = hcnt[0].
- ACTIVE line:
  - `href` = 1 for hcnt < 2·H_ACTIVE, otherwise 0.
  - Phase 0 outputs pixel[15:8]; phase 1 outputs pixel[7:0].
  - `data` = 0 whenever `href` = 0.
- `pattern_sel`, `zone` and `solid_rgb` are latched on entry to VSYNC. They are constant for the whole frame.
- Patterns, with x in 0..319 and y in 0..239:
  - Colour bars: bar index = x/40. Bars in order are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Red box: F800 inside a 48×48 box, 0000 elsewhere.
    - Box x0 = {29, 136, 243}[zone%3]; y0 = {16, 96, 176}[zone/3].
    - The box is inclusive of x0..x0+47 and y0..y0+47.
    - For zone ≥ 9, the whole frame is 0000.
  - Gradient: R = x[8:4], G = y[7:2], B = 0, i.e. {x[8:4], y[7:2], 5'b0}.
  - Solid: latched `solid_rgb`.
- `frame_done`:
  - Pulses on the final VFRONT cycle.
  - `frame_count` increments on the same edge.
- `en` behaviour:
  - Dropping `en` mid-frame does not truncate; the current frame completes.
  - Raising `en` in IDLE starts VSYNC on the next edge.

## Timing
- All outputs are registered.
- `href` and `data` change on the same `ov7670_pclk` edge. The first byte of a line is valid in the cycle `href` first reads 1.
- `vsync`:
  - Rises on the first VSYNC cycle.
  - Falls on the first VBACK cycle, which is the capture-side frame start.
  - Rises again at the next frame's VSYNC, which is the capture-side frame end.
- With defaults:
  - `vsync` is high for 2352 cycles.
  - The first `href` rises 17·784 = 13328 cycles after `vsync` falls.
  - Frame length = 270·784 = 211680 cycles.
- Reset value of every output is 0: `vsync`, `href`, `data`, `frame_done`, `frame_count`, `busy`. The FSM resets to IDLE and all counters to 0.
- Reset asserted mid-line or mid-frame:
  - All outputs go to 0 immediately, asynchronously.
  - After release, restart is always from VSYNC with a full frame. A partial frame is never resumed.
- `frame_count` wraps from FFFF to 0000 with no other side effect.

## Test plan
- **Reset:** assert `reset` mid-ACTIVE with `en` = 1 → all outputs 0 in the same cycle. After release, `vsync` rises 1 cycle later and the frame that follows has full length.
- **Frame structure, defaults, `en` held high:**
  - Exactly 240 `href` pulses per frame, each 640 cycles long.
  - `vsync` high for 2352 cycles.
  - `vsync` fall to `vsync` rise = 209328 cycles.
  - `frame_done` every 211680 cycles.
- **Colour bars:** pixel 0 bytes = FF, FF. Pixel 200 bytes = F8, 00. Pixel 319 bytes = 00, 00. `data` = 00 during H_BLANK.
- **Red box, `zone` = 4:** pixel (136, 96) = F800; (183, 143) = F800; (135, 96) = 0000; (184, 143) = 0000. With `zone` = 12, every pixel = 0000.
- **Pattern latch:** change `pattern_sel` from 00 to 11 mid-frame → current frame remains colour bars; the next frame is solid `solid_rgb`.
- **`en` drop:** deassert `en` during ACTIVE line 100 → frame completes, `frame_done` pulses once, `frame_count` increments by 1, then IDLE with `busy` = 0 and `vsync` = 0.
